// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage state encoding and exception codes
package cpu_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} fetch_state_t;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   function automatic logic misaligned(input logic [31:0] a);
      return a[1:0] != 2'b00;
   endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: pc-stage request, icache read port and id-stage delivery bundle
interface fetch_ctrl_if;
   logic [31:0] pc_i;
   logic        req_valid_i;
   logic        fetch_ready_o;
   logic        flush_i;
   logic        stall_i;
   logic        icache_ren_o;
   logic [31:0] icache_addr_o;
   logic        icache_ok_i;
   logic [31:0] icache_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        adel_o;
   modport master (
      input  pc_i, req_valid_i, flush_i, stall_i, icache_ok_i, icache_rdata_i,
      output fetch_ready_o, icache_ren_o, icache_addr_o, inst_valid_o, inst_o, pc_o, adel_o
   );
   modport slave (
      output pc_i, req_valid_i, flush_i, stall_i, icache_ok_i, icache_rdata_i,
      input  fetch_ready_o, icache_ren_o, icache_addr_o, inst_valid_o, inst_o, pc_o, adel_o
   );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding icache fetch FSM with stall hold register and flush drop
module fetch_ctrl
   import cpu_pkg::*;
(
   input logic         clk,
   input logic         rst,
   fetch_ctrl_if.master bus
);
   fetch_state_t state, state_nx, issue, post;
   logic [31:0]  addr, hold_inst, hold_pc;
   logic [4:0]   hold_exc;
   logic         ready, accept, reply, capture, valid, in_wait, in_hold;
   always_comb begin
      in_wait  = state == S_WAIT;
      in_hold  = state == S_HOLD;
      ready    = rst ? 1'b0 : state == S_IDLE ? 1'b1 : in_wait ? bus.icache_ok_i && !bus.stall_i : in_hold ? !bus.stall_i : 1'b0;
      accept   = bus.req_valid_i && ready && !bus.flush_i;
      reply    = in_wait && bus.icache_ok_i && !bus.flush_i;
      capture  = reply && bus.stall_i;
      valid    = !rst && !bus.flush_i && ((reply && !bus.stall_i) || in_hold);
      issue    = misaligned(bus.pc_i) ? S_HOLD : S_WAIT;
      post     = accept ? issue : S_IDLE;
      state_nx = state == S_IDLE ? post
               : in_wait ? (bus.flush_i ? (bus.icache_ok_i ? S_IDLE : S_DROP)
                           : !bus.icache_ok_i ? S_WAIT : bus.stall_i ? S_HOLD : post)
               : in_hold ? (bus.flush_i ? S_IDLE : bus.stall_i ? S_HOLD : post)
               : (bus.icache_ok_i ? S_IDLE : S_DROP);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         addr      <= '0;
         hold_inst <= '0;
         hold_pc   <= '0;
         hold_exc  <= '0;
      end else begin
         state <= state_nx;
         if (accept && !misaligned(bus.pc_i)) addr <= bus.pc_i;
         if (accept && misaligned(bus.pc_i)) begin
            hold_inst <= '0;
            hold_pc   <= bus.pc_i;
            hold_exc  <= EXC_ADEL;
         end else if (capture) begin
            hold_inst <= bus.icache_rdata_i;
            hold_pc   <= addr;
            hold_exc  <= '0;
         end
      end
   end
   // WAIT delivers the reply combinationally; HOLD replays the captured entry
   assign bus.fetch_ready_o = ready;
   assign bus.icache_ren_o  = !rst && (in_wait || state == S_DROP);
   assign bus.icache_addr_o = rst ? '0 : addr;
   assign bus.inst_valid_o  = valid;
   assign bus.inst_o        = !valid ? '0 : in_wait ? bus.icache_rdata_i : hold_inst;
   assign bus.pc_o          = !valid ? '0 : in_wait ? addr : hold_pc;
   assign bus.adel_o        = valid && in_hold && hold_exc == EXC_ADEL;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scenario tasks with an icache model and an in-order delivery scoreboard
module tb_fetch_ctrl;
   typedef struct packed {logic [31:0] inst; logic [31:0] pc; logic adel;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   int   lat = 1;
   int   cnt = 0;
   exp_t sb[$];
   fetch_ctrl_if bus();
   fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // icache model: ok strobes on the lat-th cycle that ren is held high
   always @(posedge clk) begin
      #1;
      if (rst || !bus.icache_ren_o) begin
         bus.icache_ok_i = 1'b0;
         cnt = 0;
      end else begin
         cnt++;
         if (cnt >= lat) begin
            bus.icache_ok_i = 1'b1;
            cnt = 0;
         end else bus.icache_ok_i = 1'b0;
      end
      bus.icache_rdata_i = bus.icache_ok_i ? word(bus.icache_addr_o) : 32'hDEAD_BEEF;
   end

   // scoreboard consumer: every delivery must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && bus.inst_valid_o && !bus.stall_i) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL deliver_unexpected got pc=%h inst=%h want none", bus.pc_o, bus.inst_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({bus.inst_o, bus.pc_o, bus.adel_o} !== e) begin
               mismatched++;
               $display("FAIL deliver got inst=%h pc=%h adel=%b want inst=%h pc=%h adel=%b",
                        bus.inst_o, bus.pc_o, bus.adel_o, e.inst, e.pc, e.adel);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'h0000_1000;
      bus.flush_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.fetch_ready_o, bus.icache_ren_o, bus.inst_valid_o, bus.adel_o} !== 4'b0 ||
          {bus.icache_addr_o, bus.inst_o, bus.pc_o} !== 96'b0) begin
         mismatched++;
         $display("FAIL reset_outputs got rdy=%b ren=%b val=%b adel=%b addr=%h inst=%h pc=%h want all 0",
                  bus.fetch_ready_o, bus.icache_ren_o, bus.inst_valid_o, bus.adel_o, bus.icache_addr_o, bus.inst_o, bus.pc_o);
      end
      cyc();
      rst = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.flush_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.fetch_ready_o, bus.icache_ren_o, bus.inst_valid_o} !== 3'b100) begin
         mismatched++;
         $display("FAIL reset_idle got rdy/ren/val=%b%b%b want 100", bus.fetch_ready_o, bus.icache_ren_o, bus.inst_valid_o);
      end
   endtask

   task automatic test_single();
      lat = 1;
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'hBFC0_0000;
      sb.push_back({word(32'hBFC0_0000), 32'hBFC0_0000, 1'b0});
      @(negedge clk);
      compared++;
      if ({bus.fetch_ready_o, bus.icache_ren_o} !== 2'b10) begin
         mismatched++;
         $display("FAIL single_issue got rdy/ren=%b%b want 10", bus.fetch_ready_o, bus.icache_ren_o);
      end
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      compared++;
      if (bus.icache_ren_o !== 1'b1 || bus.icache_addr_o !== 32'hBFC0_0000 || bus.inst_valid_o !== 1'b1) begin
         mismatched++;
         $display("FAIL single_wait got ren=%b addr=%h val=%b want 1 bfc00000 1", bus.icache_ren_o, bus.icache_addr_o, bus.inst_valid_o);
      end
      cyc();
      @(negedge clk);
      compared++;
      if ({bus.icache_ren_o, bus.inst_valid_o, bus.fetch_ready_o} !== 3'b001) begin
         mismatched++;
         $display("FAIL single_idle got ren/val/rdy=%b%b%b want 001", bus.icache_ren_o, bus.inst_valid_o, bus.fetch_ready_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs[3] = '{32'hBFC0_0100, 32'hBFC0_0104, 32'hBFC0_0108};
      int run = 0;
      lat = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         bus.req_valid_i = i < 3;
         if (i < 3) begin
            bus.pc_i = pcs[i];
            sb.push_back({word(pcs[i]), pcs[i], 1'b0});
         end
         @(negedge clk);
         if (i > 0 && bus.inst_valid_o === 1'b1) run++;
         if (i < 3) begin
            compared++;
            if (bus.fetch_ready_o !== 1'b1) begin
               mismatched++;
               $display("FAIL b2b_ready cycle %0d got %b want 1", i, bus.fetch_ready_o);
            end
         end
      end
      compared++;
      if (run !== 3) begin
         mismatched++;
         $display("FAIL b2b_run got %0d valid cycles want 3", run);
      end
      cyc();
      @(negedge clk);
   endtask

   task automatic test_stall();
      int vcnt = 0;
      lat = 1;
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'hBFC0_0200;
      sb.push_back({word(32'hBFC0_0200), 32'hBFC0_0200, 1'b0});
      cyc();
      bus.req_valid_i = 1'b0;
      bus.stall_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.inst_valid_o, bus.fetch_ready_o, bus.icache_ok_i} !== 3'b001) begin
         mismatched++;
         $display("FAIL stall_reply got val/rdy/ok=%b%b%b want 001", bus.inst_valid_o, bus.fetch_ready_o, bus.icache_ok_i);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         bus.stall_i = i < 2;
         @(negedge clk);
         if (bus.inst_valid_o === 1'b1) vcnt++;
         compared++;
         if (bus.inst_o !== word(32'hBFC0_0200) || bus.fetch_ready_o !== (i == 2)) begin
            mismatched++;
            $display("FAIL stall_hold cycle %0d got inst=%h rdy=%b want %h %b", i, bus.inst_o, bus.fetch_ready_o, word(32'hBFC0_0200), i == 2);
         end
      end
      compared++;
      if (vcnt !== 3) begin
         mismatched++;
         $display("FAIL stall_valid_cycles got %0d want 3", vcnt);
      end
      cyc();
      @(negedge clk);
      compared++;
      if (bus.inst_valid_o !== 1'b0) begin
         mismatched++;
         $display("FAIL stall_after got val=%b want 0", bus.inst_valid_o);
      end
   endtask

   task automatic test_adel();
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'hBFC0_0002;
      sb.push_back({32'h0, 32'hBFC0_0002, 1'b1});
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.icache_ren_o, bus.inst_valid_o, bus.adel_o} !== 3'b011) begin
         mismatched++;
         $display("FAIL adel got ren/val/adel=%b%b%b want 011", bus.icache_ren_o, bus.inst_valid_o, bus.adel_o);
      end
      cyc();
      @(negedge clk);
   endtask

   task automatic test_flush_drop();
      lat = 3;
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'hBFC0_0300;
      cyc();
      bus.req_valid_i = 1'b0;
      bus.flush_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.icache_ren_o, bus.inst_valid_o} !== 2'b10) begin
         mismatched++;
         $display("FAIL drop_flush got ren/val=%b%b want 10", bus.icache_ren_o, bus.inst_valid_o);
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         bus.flush_i = i == 1;
         @(negedge clk);
         compared++;
         if ({bus.icache_ren_o, bus.fetch_ready_o, bus.inst_valid_o} !== 3'b100 || bus.icache_addr_o !== 32'hBFC0_0300) begin
            mismatched++;
            $display("FAIL drop_hold cycle %0d got ren/rdy/val=%b%b%b addr=%h want 100 bfc00300",
                     i, bus.icache_ren_o, bus.fetch_ready_o, bus.inst_valid_o, bus.icache_addr_o);
         end
      end
      cyc();
      bus.flush_i = 1'b0;
      lat = 1;
      @(negedge clk);
      compared++;
      if ({bus.icache_ren_o, bus.fetch_ready_o, bus.inst_valid_o} !== 3'b010) begin
         mismatched++;
         $display("FAIL drop_exit got ren/rdy/val=%b%b%b want 010", bus.icache_ren_o, bus.fetch_ready_o, bus.inst_valid_o);
      end
   endtask

   task automatic test_flush_reply();
      lat = 1;
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'hBFC0_0400;
      cyc();
      bus.req_valid_i = 1'b0;
      bus.flush_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.icache_ok_i, bus.inst_valid_o} !== 2'b10) begin
         mismatched++;
         $display("FAIL flush_reply got ok/val=%b%b want 10", bus.icache_ok_i, bus.inst_valid_o);
      end
      cyc();
      bus.flush_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.icache_ren_o, bus.inst_valid_o} !== 2'b00) begin
         mismatched++;
         $display("FAIL flush_reply_idle got ren/val=%b%b want 00", bus.icache_ren_o, bus.inst_valid_o);
      end
   endtask

   task automatic test_hold_flush();
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'hBFC0_0501;
      bus.stall_i = 1'b1;
      cyc();
      bus.req_valid_i = 1'b0;
      bus.flush_i = 1'b1;
      @(negedge clk);
      compared++;
      if (bus.inst_valid_o !== 1'b0) begin
         mismatched++;
         $display("FAIL hold_flush got val=%b want 0", bus.inst_valid_o);
      end
      cyc();
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.inst_valid_o, bus.fetch_ready_o} !== 2'b01) begin
         mismatched++;
         $display("FAIL hold_flush_idle got val/rdy=%b%b want 01", bus.inst_valid_o, bus.fetch_ready_o);
      end
   endtask

   task automatic test_reset_in_wait();
      lat = 5;
      cyc();
      bus.req_valid_i = 1'b1;
      bus.pc_i = 32'hBFC0_0600;
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      compared++;
      if (bus.icache_ren_o !== 1'b1) begin
         mismatched++;
         $display("FAIL rstwait_ren got %b want 1", bus.icache_ren_o);
      end
      cyc();
      rst = 1'b1;
      bus.flush_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.fetch_ready_o, bus.icache_ren_o, bus.inst_valid_o, bus.adel_o} !== 4'b0 || bus.icache_addr_o !== 32'h0) begin
         mismatched++;
         $display("FAIL rstwait_during got rdy/ren/val/adel=%b%b%b%b addr=%h want 0000 0",
                  bus.fetch_ready_o, bus.icache_ren_o, bus.inst_valid_o, bus.adel_o, bus.icache_addr_o);
      end
      cyc();
      rst = 1'b0;
      bus.flush_i = 1'b0;
      lat = 1;
      @(negedge clk);
      compared++;
      if ({bus.icache_ren_o, bus.inst_valid_o, bus.fetch_ready_o} !== 3'b001 || bus.icache_addr_o !== 32'h0) begin
         mismatched++;
         $display("FAIL rstwait_after got ren/val/rdy=%b%b%b addr=%h want 001 0",
                  bus.icache_ren_o, bus.inst_valid_o, bus.fetch_ready_o, bus.icache_addr_o);
      end
   endtask

   initial begin
      bus.pc_i = '0;
      bus.req_valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      bus.icache_ok_i = 1'b0;
      bus.icache_rdata_i = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_adel();
      test_flush_drop();
      test_flush_reply();
      test_hold_flush();
      test_reset_in_wait();
      cyc();
      @(negedge clk);
      compared++;
      if (sb.size() !== 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
